// File: rtl/ex_redirect_ctrl_pkg.sv
// Shared state type and sizing defaults for the exception/ERET redirect controller.
package ex_redirect_ctrl_pkg;

    localparam int EXR_MAX_OUTST = 2;

    typedef enum logic [1:0] {
        EXR_IDLE  = 2'd0,
        EXR_DRAIN = 2'd1,
        EXR_REDIR = 2'd2
    } exr_state_e;

endpackage

// File: rtl/ex_redirect_ctrl_outst_counter.sv
// Up/down counter of outstanding instruction-SRAM requests with full/empty flags.
module ex_redirect_ctrl_outst_counter #(
    parameter int MAX_OUTST = 2,
    parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_full,
    output logic o_empty,
    output logic o_next_zero
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_countNext;

    assign o_full      = (r_count == CNT_W'(MAX_OUTST));
    assign o_empty     = (r_count == '0);
    assign o_next_zero = (w_countNext == '0);

    // Simultaneous inc/dec cancel; saturate at both ends so a stray response cannot wrap.
    always_comb begin
        w_countNext = r_count;
        case ({i_inc, i_dec})
            2'b10: if (!o_full)  w_countNext = r_count + CNT_W'(1);
            2'b01: if (!o_empty) w_countNext = r_count - CNT_W'(1);
            default: w_countNext = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_count <= '0;
        else       r_count <= w_countNext;
    end

endmodule

// File: rtl/ex_redirect_ctrl.sv
// Flush/redirect sequencer for WB exceptions and ERET; waits for the instruction bus to drain.
// Optional REDIRECT_PERF_CNT_EN adds exception and drain-cycle performance counters.
module ex_redirect_ctrl
    import ex_redirect_ctrl_pkg::*;
#(
    parameter int MAX_OUTST = EXR_MAX_OUTST
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_ws_handle_ex,
    input  logic [31:0] i_ex_pc,
    input  logic        i_has_int,
    input  logic        i_inst_req_fire,
    input  logic        i_inst_resp_fire,
    output logic        o_flush,
    output logic        o_req_block,
    output logic        o_drop_resp,
    output logic        o_redirect_valid,
    output logic [31:0] o_redirect_pc,
    input  logic        i_redirect_ready,
    output logic        o_int_req
`ifdef REDIRECT_PERF_CNT_EN
    ,
    output logic [31:0] o_ex_cnt,
    output logic [31:0] o_drain_cyc
`endif
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    exr_state_e  r_state;
    exr_state_e  w_stateNext;
    logic [31:0] r_tgt;
    logic        w_full;
    logic        w_empty;
    logic        w_nextZero;
    logic        w_exAccept;

    assign w_exAccept = (r_state == EXR_IDLE) && i_ws_handle_ex;

    ex_redirect_ctrl_outst_counter #(
        .MAX_OUTST (MAX_OUTST),
        .CNT_W     (CNT_W)
    ) u_outst (
        .clk         (clk),
        .reset       (reset),
        .i_inc       (i_inst_req_fire),
        .i_dec       (i_inst_resp_fire),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_next_zero (w_nextZero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= EXR_IDLE;
            r_tgt   <= '0;
        end else begin
            r_state <= w_stateNext;
            if (w_exAccept) r_tgt <= i_ex_pc;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            EXR_IDLE:  if (i_ws_handle_ex)   w_stateNext = w_nextZero ? EXR_REDIR : EXR_DRAIN;
            EXR_DRAIN: if (w_nextZero)       w_stateNext = EXR_REDIR;
            EXR_REDIR: if (i_redirect_ready) w_stateNext = EXR_IDLE;
            default:                         w_stateNext = EXR_IDLE;
        endcase
    end

    // In REDIR the request block stays up; IF issues the redirect fetch on its own path.
    always_comb begin
        o_flush          = 1'b0;
        o_req_block      = w_full;
        o_drop_resp      = 1'b0;
        o_redirect_valid = 1'b0;
        o_redirect_pc    = '0;
        o_int_req        = 1'b0;
        case (r_state)
            EXR_IDLE: begin
                o_flush   = i_ws_handle_ex;
                o_int_req = i_has_int && !i_ws_handle_ex;
            end
            EXR_DRAIN: begin
                o_flush     = 1'b1;
                o_req_block = 1'b1;
                o_drop_resp = i_inst_resp_fire;
            end
            EXR_REDIR: begin
                o_req_block      = 1'b1;
                o_redirect_valid = 1'b1;
                o_redirect_pc    = r_tgt;
            end
            default: o_req_block = 1'b1;
        endcase
    end

`ifdef REDIRECT_PERF_CNT_EN
    logic [31:0] r_exCnt;
    logic [31:0] r_drainCyc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_exCnt    <= '0;
            r_drainCyc <= '0;
        end else begin
            if (w_exAccept)            r_exCnt    <= r_exCnt + 32'd1;
            if (r_state == EXR_DRAIN)  r_drainCyc <= r_drainCyc + 32'd1;
        end
    end

    assign o_ex_cnt    = r_exCnt;
    assign o_drain_cyc = r_drainCyc;
`endif

    a_noExOutsideIdle: assert property (@(posedge clk) disable iff (reset)
        (r_state != EXR_IDLE) |-> !i_ws_handle_ex);

    a_noRespUnderflow: assert property (@(posedge clk) disable iff (reset)
        !(i_inst_resp_fire && !i_inst_req_fire && w_empty));

endmodule

// File: tb/tb_ex_redirect_ctrl.sv
// Self-checking bench for ex_redirect_ctrl: per-cycle model comparison plus directed literal checks.
module tb_ex_redirect_ctrl;

    localparam int MAXO = 2;
    localparam logic [31:0] EXC_ENTRY = 32'hbfc00380;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wsHandleEx = 1'b0;
    logic [31:0] exPc = '0;
    logic        hasInt = 1'b0;
    logic        reqFire = 1'b0;
    logic        respFire = 1'b0;
    logic        redirReady = 1'b0;
    logic        flush, reqBlock, dropResp, redirValid, intReq;
    logic [31:0] redirPc;
`ifdef REDIRECT_PERF_CNT_EN
    logic [31:0] exCnt, drainCyc;
`endif

    int checks = 0;
    int errors = 0;

    ex_redirect_ctrl #(.MAX_OUTST(MAXO)) dut (
        .clk              (clk),
        .reset            (reset),
        .i_ws_handle_ex   (wsHandleEx),
        .i_ex_pc          (exPc),
        .i_has_int        (hasInt),
        .i_inst_req_fire  (reqFire),
        .i_inst_resp_fire (respFire),
        .o_flush          (flush),
        .o_req_block      (reqBlock),
        .o_drop_resp      (dropResp),
        .o_redirect_valid (redirValid),
        .o_redirect_pc    (redirPc),
        .i_redirect_ready (redirReady),
        .o_int_req        (intReq)
`ifdef REDIRECT_PERF_CNT_EN
        ,
        .o_ex_cnt         (exCnt),
        .o_drain_cyc      (drainCyc)
`endif
    );

    always #5 clk = ~clk;

    // Model: "busy" means an exception is pending its redirect; "drained" means the bus hit zero since.
    bit          mValid = 1'b0;
    int          mOutst = 0;
    bit          mBusy = 1'b0;
    bit          mDrained = 1'b0;
    logic [31:0] mTgt = '0;
    int unsigned mExCnt = 0;
    int unsigned mDrainCyc = 0;

    always @(posedge clk) begin
        int n;
        if (reset) begin
            mValid = 1'b1; mOutst = 0; mBusy = 1'b0; mDrained = 1'b0; mTgt = '0;
            mExCnt = 0; mDrainCyc = 0;
        end else begin
            n = mOutst + int'(reqFire) - int'(respFire);
            if (n < 0) n = 0;
            if (n > MAXO) n = MAXO;
            if (mBusy && !mDrained) mDrainCyc++;
            if (!mBusy) begin
                if (wsHandleEx) begin
                    mBusy = 1'b1; mTgt = exPc; mDrained = (n == 0); mExCnt++;
                end
            end else if (!mDrained) begin
                if (n == 0) mDrained = 1'b1;
            end else if (redirReady) begin
                mBusy = 1'b0; mDrained = 1'b0;
            end
            mOutst = n;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: inputs change at negedge, outputs settle well before the next posedge.
    always @(negedge clk) begin
        #2;
        if (mValid) begin
            logic eFlush, eBlock, eDrop, eValid, eInt;
            eFlush = mBusy ? !mDrained : wsHandleEx;
            eBlock = mBusy || (mOutst == MAXO);
            eDrop  = mBusy && !mDrained && respFire;
            eValid = mBusy && mDrained;
            eInt   = !mBusy && hasInt && !wsHandleEx;
            checkOutput("m_flush", 32'(flush), 32'(eFlush));
            checkOutput("m_req_block", 32'(reqBlock), 32'(eBlock));
            checkOutput("m_drop_resp", 32'(dropResp), 32'(eDrop));
            checkOutput("m_redirect_valid", 32'(redirValid), 32'(eValid));
            checkOutput("m_int_req", 32'(intReq), 32'(eInt));
            if (eValid) checkOutput("m_redirect_pc", redirPc, mTgt);
`ifdef REDIRECT_PERF_CNT_EN
            checkOutput("m_ex_cnt", exCnt, mExCnt);
            checkOutput("m_drain_cyc", drainCyc, mDrainCyc);
`endif
        end
    end

    task automatic applyStimulus(input logic ws, input logic [31:0] pc, input logic hi,
                                 input logic rq, input logic rs, input logic rdy);
        @(negedge clk);
        wsHandleEx = ws; exPc = pc; hasInt = hi;
        reqFire = rq; respFire = rs; redirReady = rdy;
        #3;
    endtask

    task automatic idle();
        applyStimulus(0, 32'h0, 0, 0, 0, 0);
    endtask

    initial begin
        // reset state
        applyStimulus(0, 32'h0, 0, 0, 0, 0);
        checkOutput("rst_flush", 32'(flush), 32'd0);
        checkOutput("rst_redirect_valid", 32'(redirValid), 32'd0);
        checkOutput("rst_req_block", 32'(reqBlock), 32'd0);
        reset = 1'b0;
        idle();

        // 1: exception with idle bus
        applyStimulus(1, EXC_ENTRY, 0, 0, 0, 0);
        checkOutput("t1_flush_T", 32'(flush), 32'd1);
        checkOutput("t1_rv_T", 32'(redirValid), 32'd0);
        applyStimulus(0, 32'h0, 0, 0, 0, 1);
        checkOutput("t1_rv_T1", 32'(redirValid), 32'd1);
        checkOutput("t1_pc_T1", redirPc, EXC_ENTRY);
        checkOutput("t1_block_T1", 32'(reqBlock), 32'd1);
        checkOutput("t1_flush_T1", 32'(flush), 32'd0);
        idle();
        checkOutput("t1_rv_after", 32'(redirValid), 32'd0);

        // 2: two outstanding, responses at T+2 and T+4
        applyStimulus(0, 32'h0, 0, 1, 0, 0);
        applyStimulus(0, 32'h0, 0, 1, 0, 0);
        idle();
        checkOutput("t4_block_full", 32'(reqBlock), 32'd1);
        applyStimulus(1, EXC_ENTRY, 0, 0, 0, 0);
        applyStimulus(0, 32'h0, 0, 0, 0, 0);
        checkOutput("t2_flush_T1", 32'(flush), 32'd1);
        checkOutput("t2_rv_T1", 32'(redirValid), 32'd0);
        applyStimulus(0, 32'h0, 0, 0, 1, 0);
        checkOutput("t2_drop_T2", 32'(dropResp), 32'd1);
        applyStimulus(0, 32'h0, 0, 0, 0, 0);
        checkOutput("t2_drop_T3", 32'(dropResp), 32'd0);
        applyStimulus(0, 32'h0, 0, 0, 1, 0);
        checkOutput("t2_drop_T4", 32'(dropResp), 32'd1);
        checkOutput("t2_rv_T4", 32'(redirValid), 32'd0);
        applyStimulus(0, 32'h0, 0, 1, 0, 1);
        checkOutput("t2_rv_T5", 32'(redirValid), 32'd1);
        applyStimulus(0, 32'h0, 0, 0, 1, 0);
        checkOutput("t2_idle_drop", 32'(dropResp), 32'd0);

        // Response in the exception cycle is not dropped and empties the bus
        applyStimulus(0, 32'h0, 0, 1, 0, 0);
        applyStimulus(1, 32'h8000_0040, 0, 0, 1, 0);
        checkOutput("sameT_drop", 32'(dropResp), 32'd0);
        checkOutput("sameT_flush", 32'(flush), 32'd1);
        applyStimulus(0, 32'h0, 0, 0, 0, 1);
        checkOutput("sameT_rv", 32'(redirValid), 32'd1);
        checkOutput("sameT_pc", redirPc, 32'h8000_0040);

        // 3: ERET with IF stalling the redirect three cycles
        applyStimulus(1, 32'h8000_1234, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 32'h0, 0, 0, 0, 0);
            checkOutput("t3_rv_hold", 32'(redirValid), 32'd1);
            checkOutput("t3_pc_hold", redirPc, 32'h8000_1234);
        end
        applyStimulus(0, 32'h0, 0, 0, 0, 1);
        checkOutput("t3_rv_ready", 32'(redirValid), 32'd1);
        idle();
        checkOutput("t3_rv_idle", 32'(redirValid), 32'd0);

        // 4: simultaneous req/resp at outst=1 keeps one outstanding
        applyStimulus(0, 32'h0, 0, 1, 0, 0);
        applyStimulus(0, 32'h0, 0, 1, 1, 0);
        checkOutput("t4_nodrop_idle", 32'(dropResp), 32'd0);
        idle();
        checkOutput("t4_block_one", 32'(reqBlock), 32'd0);
        applyStimulus(1, EXC_ENTRY, 0, 0, 0, 0);
        applyStimulus(0, 32'h0, 0, 0, 0, 0);
        checkOutput("t4_still_drain", 32'(redirValid), 32'd0);
        applyStimulus(0, 32'h0, 0, 0, 1, 0);
        checkOutput("t4_drop", 32'(dropResp), 32'd1);
        applyStimulus(0, 32'h0, 0, 0, 0, 1);
        checkOutput("t4_rv", 32'(redirValid), 32'd1);

        // 5: interrupt tagging only in IDLE without a concurrent exception
        applyStimulus(0, 32'h0, 1, 0, 0, 0);
        checkOutput("t5_int_idle", 32'(intReq), 32'd1);
        applyStimulus(0, 32'h0, 1, 1, 0, 0);
        applyStimulus(1, EXC_ENTRY, 1, 0, 0, 0);
        checkOutput("t5_int_ex", 32'(intReq), 32'd0);
        applyStimulus(0, 32'h0, 1, 0, 0, 0);
        checkOutput("t5_int_drain", 32'(intReq), 32'd0);
        applyStimulus(0, 32'h0, 1, 0, 1, 0);
        applyStimulus(0, 32'h0, 1, 0, 0, 0);
        checkOutput("t5_int_redir", 32'(intReq), 32'd0);
        checkOutput("t5_rv_redir", 32'(redirValid), 32'd1);
        applyStimulus(0, 32'h0, 1, 0, 0, 1);
        idle();

        // 6: reset in DRAIN with two outstanding
        applyStimulus(0, 32'h0, 0, 1, 0, 0);
        applyStimulus(0, 32'h0, 0, 1, 0, 0);
        applyStimulus(1, EXC_ENTRY, 0, 0, 0, 0);
        applyStimulus(0, 32'h0, 0, 0, 0, 0);
        checkOutput("t6_in_drain", 32'(flush), 32'd1);
        reset = 1'b1;
        idle();
        reset = 1'b0;
        idle();
        checkOutput("t6_flush", 32'(flush), 32'd0);
        checkOutput("t6_block", 32'(reqBlock), 32'd0);
        checkOutput("t6_rv", 32'(redirValid), 32'd0);
        applyStimulus(1, 32'h8000_0100, 0, 0, 0, 0);
        applyStimulus(0, 32'h0, 0, 0, 0, 1);
        checkOutput("t6_cnt_zero_rv", 32'(redirValid), 32'd1);
        checkOutput("t6_pc", redirPc, 32'h8000_0100);
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
